ps2_frame_io: RTL and testbench

Bit-level PS/2 link layer between the keyboard connector pins and the scancode decoder. Receives device-to-host 11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents each byte as a one-cycle strobe with a matching error strobe. It also sends single host-to-device command bytes (e.g. 0xFF reset, 0xED LED set) under a valid/ready handshake. Pin outputs are open-drain requests; the top level maps them to tri-state pads.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_frame_io.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_frame_io.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 link layer shared types: FSM states, timing constants, parity.
// Timing helpers take the system clock frequency in Hz.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_INH,
    TX_REQ,
    TX_BITS,
    TX_ACK
  } state_e;

  // 100 us bit watchdog
  function automatic int t_bit(input int f);
    return f / 10000;
  endfunction

  // 120 us host inhibit
  function automatic int t_inh(input int f);
    return f * 12 / 100000;
  endfunction

  // 15 ms transmit limit
  function automatic int t_tx(input int f);
    return f * 15 / 1000;
  endfunction

  // bit that makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus hold filter for one PS/2 pin.
// Ports: clk, rst, pin_i (raw async pin), lvl_o (filtered level).
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic lvl_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic [CW-1:0] cnt_q;

  // a new level must persist FILT_LEN cycles before it is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      lvl_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        lvl_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign lvl_o = lvl_q;

endmodule

// File: rtl/ps2_frame_io.sv
// PS/2 bit-level link: 11-bit device frames in, host command bytes out.
// Pins: ps2_clk/dat in (raw), out (open-drain, 0 = pull low).
module ps2_frame_io
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ = 28000000,
  parameter int FILT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic [7:0] dataout,
  output logic       dataout_valid,
  output logic       dataout_error,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int TB = t_bit(CLK_FREQ);
  localparam int TI = t_inh(CLK_FREQ);
  localparam int TT = t_tx(CLK_FREQ);
  localparam int BW = $clog2(TB);
  localparam int TW = $clog2(TT);

  logic clk_f;
  logic dat_f;
  logic fall;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk  (clk),
    .rst  (rst),
    .pin_i(ps2_clk_in),
    .lvl_o(clk_f)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk  (clk),
    .rst  (rst),
    .pin_i(ps2_dat_in),
    .lvl_o(dat_f)
  );

  state_e        state_q, state_d;
  logic          cprev_q;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [10:0]   shift_q, shift_d;
  logic [7:0]    dout_q, dout_d;
  logic [BW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] ttmr_q, ttmr_d;
  logic [7:0]    txb_q, txb_d;
  logic          txbit_q, txbit_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          txerr_q, txerr_d;

  assign fall = cprev_q & ~clk_f;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    tmr_d   = tmr_q;
    ttmr_d  = ttmr_q;
    txb_d   = txb_q;
    txbit_d = txbit_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    txerr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d  = '0;
        bcnt_d = '0;
        if (fall) begin
          // the edge that wakes us is the start bit
          state_d = RX;
          shift_d = {dat_f, shift_q[10:1]};
          bcnt_d  = 4'd1;
        end else if (tx_valid) begin
          state_d = TX_INH;
          txb_d   = tx_data;
          ttmr_d  = '0;
        end
      end
      RX: begin
        if (fall) begin
          shift_d = {dat_f, shift_q[10:1]};
          bcnt_d  = bcnt_q + 4'd1;
          tmr_d   = '0;
          if (bcnt_q == 4'd10) begin
            state_d = IDLE;
            if (!shift_d[0] && shift_d[10] &&
                shift_d[9] == odd_parity(shift_d[8:1])) begin
              dout_d = shift_d[8:1];
              vld_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (tmr_q == BW'(TB - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      TX_INH: begin
        if (ttmr_q == TW'(TI - 1)) begin
          state_d = TX_REQ;
          ttmr_d  = '0;
          txbit_d = 1'b0;
        end else begin
          ttmr_d = ttmr_q + 1'b1;
        end
      end
      TX_REQ: begin
        state_d = TX_BITS;
        bcnt_d  = '0;
        ttmr_d  = ttmr_q + 1'b1;
      end
      TX_BITS: begin
        ttmr_d = ttmr_q + 1'b1;
        if (ttmr_q == TW'(TT - 1)) begin
          state_d = IDLE;
          txerr_d = 1'b1;
        end else if (fall) begin
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q < 4'd8) begin
            txbit_d = txb_q[bcnt_q[2:0]];
          end else if (bcnt_q == 4'd8) begin
            txbit_d = odd_parity(txb_q);
          end else begin
            txbit_d = 1'b1;
            state_d = TX_ACK;
          end
        end
      end
      TX_ACK: begin
        ttmr_d = ttmr_q + 1'b1;
        if (ttmr_q == TW'(TT - 1)) begin
          state_d = IDLE;
          txerr_d = 1'b1;
        end else if (fall) begin
          state_d = IDLE;
          done_d  = ~dat_f;
          txerr_d = dat_f;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cprev_q <= 1'b1;
      bcnt_q  <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      tmr_q   <= '0;
      ttmr_q  <= '0;
      txb_q   <= '0;
      txbit_q <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      txerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cprev_q <= clk_f;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      tmr_q   <= tmr_d;
      ttmr_q  <= ttmr_d;
      txb_q   <= txb_d;
      txbit_q <= txbit_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      done_q  <= done_d;
      txerr_q <= txerr_d;
    end
  end

  assign ps2_clk_out   = (state_q != TX_INH);
  assign ps2_dat_out   = (state_q == TX_REQ || state_q == TX_BITS)
                         ? txbit_q : 1'b1;
  // an incoming frame pre-empts a same-cycle send request
  assign tx_ready      = (state_q == IDLE) && !fall;
  assign dataout       = dout_q;
  assign dataout_valid = vld_q;
  assign dataout_error = err_q;
  assign tx_done       = done_q;
  assign tx_error      = txerr_q;

endmodule

// File: tb/tb_ps2_frame_io.sv
// Bench for ps2_frame_io: open-drain device model, frame/parity model.
// Runs at a reduced CLK_FREQ so the 15 ms timeout stays short.
`timescale 1ns/1ps
module tb_ps2_frame_io;

  localparam int CF   = 2000000;
  localparam int FL   = 8;
  localparam int TBIT = CF / 10000;
  localparam int TINH = CF * 12 / 100000;
  localparam int TTX  = CF * 15 / 1000;
  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  logic       ps2_clk_out, ps2_dat_out;
  logic [7:0] dataout;
  logic       dataout_valid, dataout_error;
  logic       tx_ready, tx_done, tx_error;

  wire pclk = dev_clk & ps2_clk_out;
  wire pdat = dev_dat & ps2_dat_out;

  ps2_frame_io #(.CLK_FREQ(CF), .FILT_LEN(FL)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_in   (pclk),
    .ps2_dat_in   (pdat),
    .ps2_clk_out  (ps2_clk_out),
    .ps2_dat_out  (ps2_dat_out),
    .dataout      (dataout),
    .dataout_valid(dataout_valid),
    .dataout_error(dataout_error),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx_error     (tx_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vld_n = 0, err_n = 0, done_n = 0, txerr_n = 0;
  int both_n = 0, rdy_bad = 0, tx_base = 0, err_cyc = 0;
  int last_fall = 0;
  logic in_tx = 1'b0;
  logic [7:0] exp_dout = 8'h00;

  int npass = 0, ntot = 0, nfail = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (in_tx && tx_ready && !tx_done && !tx_error &&
        (done_n + txerr_n == tx_base))
      rdy_bad++;
    if (dataout_valid && dataout_error) both_n++;
    if (dataout_valid) vld_n++;
    if (dataout_error) begin
      err_n++;
      err_cyc = cyc;
    end
    if (tx_done) done_n++;
    if (tx_error) txerr_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    ntot++;
    assert (obs >= lo && obs <= hi) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // kind: 0 good, 1 parity flipped, 2 start high, 3 stop low
  function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                           input int kind);
    logic [10:0] f;
    logic p;
    p = ($countones(b) % 2 == 0);
    f = {1'b1, p, b, 1'b0};
    if (kind == 1) f[9] = ~p;
    if (kind == 2) f[0] = 1'b1;
    if (kind == 3) f[10] = 1'b0;
    return f;
  endfunction

  function automatic logic frame_ok(input logic [10:0] f);
    return !f[0] && f[10] && ($countones(f[9:1]) % 2 == 1);
  endfunction

  task automatic dev_send(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      dev_dat = f[i];
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] b,
                          input int kind);
    logic [10:0] f;
    logic ok;
    int v0, e0;
    f = mk_frame(b, kind);
    ok = frame_ok(f);
    v0 = vld_n;
    e0 = err_n;
    dev_send(f, 11);
    if (ok) exp_dout = b;
    chk({tag, "_vld"}, vld_n - v0, ok ? 1 : 0);
    chk({tag, "_err"}, err_n - e0, ok ? 0 : 1);
    chk({tag, "_dout"}, dataout, exp_dout);
  endtask

  task automatic tx_begin(input logic [7:0] b);
    int n;
    chk("tx_rdy_idle", tx_ready, 1);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    tx_base = done_n + txerr_n;
    in_tx = 1'b1;
    n = 0;
    while (ps2_clk_out === 1'b0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("inh_len", n, TINH);
    chk("start_bit", ps2_dat_out, 0);
  endtask

  task automatic tx_clock(input int nb, output logic [10:0] g);
    g = '1;
    repeat (HALF) @(negedge clk);
    g[0] = pdat;
    for (int i = 1; i <= nb; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      g[i] = pdat;
    end
  endtask

  task automatic tx_full(input string tag, input logic [7:0] b,
                         input logic ack);
    logic [10:0] g;
    int d0, e0, w;
    tx_begin(b);
    d0 = done_n;
    e0 = txerr_n;
    tx_clock(10, g);
    chk({tag, "_start"}, g[0], 0);
    chk({tag, "_data"}, g[8:1], b);
    chk({tag, "_par"}, g[9], ($countones(b) % 2 == 0) ? 1 : 0);
    chk({tag, "_stop"}, g[10], 1);
    dev_dat = ack ? 1'b0 : 1'b1;
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    w = 0;
    while (done_n + txerr_n == tx_base && w < 300) begin
      @(negedge clk);
      w++;
    end
    in_tx = 1'b0;
    chk({tag, "_done"}, done_n - d0, ack ? 1 : 0);
    chk({tag, "_txerr"}, txerr_n - e0, ack ? 0 : 1);
    chk({tag, "_rdy_low"}, rdy_bad, 0);
    chk({tag, "_rdy_back"}, tx_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, d0, t0, w;
    logic [10:0] g;

    repeat (4) @(negedge clk);
    chk("rst_clk_out", ps2_clk_out, 1);
    chk("rst_dat_out", ps2_dat_out, 1);
    chk("rst_dout", dataout, 8'h00);
    chk("rst_strobes", {dataout_valid, dataout_error, tx_done, tx_error}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", tx_ready, 1);

    rx_frame("rx1c", 8'h1C, 0);
    rx_frame("rx1c_badpar", 8'h1C, 1);

    v0 = vld_n;
    e0 = err_n;
    dev_send(mk_frame(8'h1C, 0), 5);
    w = 0;
    while (err_n == e0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("rxto_err", err_n - e0, 1);
    chk("rxto_vld", vld_n - v0, 0);
    chk_rng("rxto_lat", err_cyc - last_fall, TBIT, TBIT + FL + 10);
    chk("rxto_dout", dataout, exp_dout);
    rx_frame("rxf0", 8'hF0, 0);

    for (int i = 0; i < 5; i++)
      rx_frame("rxrnd", 8'($urandom), int'($urandom_range(0, 3)));

    tx_full("txff", 8'hFF, 1'b1);
    tx_full("txnack", 8'hED, 1'b0);
    tx_full("txrnd", 8'($urandom), 1'b1);

    e0 = txerr_n;
    d0 = done_n;
    tx_begin(8'hED);
    t0 = cyc;
    w = 0;
    while (txerr_n == e0 && w < TTX + 500) begin
      @(negedge clk);
      w++;
    end
    in_tx = 1'b0;
    chk_rng("txto_lat", cyc - t0, TTX - 2, TTX + 2);
    chk("txto_done", done_n - d0, 0);
    @(negedge clk);
    chk("txto_lines", {ps2_clk_out, ps2_dat_out}, 2'b11);

    v0 = vld_n;
    e0 = err_n;
    dev_send(mk_frame(8'hA5, 0), 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_dout = 8'h00;
    @(negedge clk);
    chk("rstrx_lines", {ps2_clk_out, ps2_dat_out}, 2'b11);
    chk("rstrx_dout", dataout, 8'h00);
    repeat (2 * TBIT) @(negedge clk);
    chk("rstrx_nostb", (vld_n - v0) + (err_n - e0), 0);
    rx_frame("rx_after_rst", 8'h3B, 0);

    v0 = vld_n;
    e0 = err_n;
    d0 = done_n + txerr_n;
    tx_begin(8'h3C);
    tx_clock(4, g);
    chk("rsttx_d0", g[1], 0);
    in_tx = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rsttx_lines", {ps2_clk_out, ps2_dat_out}, 2'b11);
    chk("rsttx_ready", tx_ready, 1);
    repeat (2 * TBIT) @(negedge clk);
    chk("rsttx_nostb", (done_n + txerr_n - d0) + (vld_n - v0) + (err_n - e0), 0);
    rx_frame("rx_after_txrst", 8'h5A, 0);

    chk("never_both", both_n, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
